riscv_multicycle: RTL
=====================

// Module: riscv_multicycle
// PURPOSE
//  Multi-cycle RV32I-subset core. One instruction moves through FETCH/DECODE/EXEC/MEM/WB
//  over several cycles, using one shared memory port with a req/ready handshake (wait states
//  allowed). It replaces the single-cycle top wherever instruction and data memory are one
//  array, or where memory has latency. Traps on illegal/misaligned ops and on a memory timeout.
// PARAMETERS
//  WIDTH        32        datapath/address width; only 32 supported (RV32)
//  RESET_PC     32'h0     PC loaded on reset
//  MEM_TIMEOUT  16        max cycles a mem_req may wait for mem_ready before TRAP (>=1)
//  CNT_W        32        width of retired-instruction counter
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous, active-high reset
//  mem_req      out  1       memory access request
//  mem_we       out  1       1=store, 0=read (fetch or load); valid while mem_req
//  mem_addr     out  WIDTH   byte address, always word-aligned
//  mem_wdata    out  WIDTH   store data; valid while mem_req&mem_we
//  mem_rdata    in   WIDTH   read data; sampled on the edge where mem_req&mem_ready
//  mem_ready    in   1       access completes on the edge where mem_req&mem_ready
//  a0           out  WIDTH   live value of x10
//  retire       out  1       1-cycle pulse when an instruction commits
//  retired_cnt  out  CNT_W   instructions committed since reset; wraps to 0
//  trapped      out  1       sticky: core halted in TRAP
// BEHAVIOUR
//  - Reset (async): pc=RESET_PC, state=FETCH, x0..x31=0, IR=0, counters=0, all outputs 0.
//    On the first cycle after release, mem_req=1 with mem_addr=RESET_PC.
//  - Ops: add sub and or slt addi lw sw beq bne jal lui. Any other opcode/funct -> TRAP.
//  - FETCH: req=1, we=0, addr=pc. On handshake, IR<=rdata, go DECODE.
//  - DECODE: A<=x[rs1], B<=x[rs2], imm sign-extended (I/S/B/J/U). Go EXEC, or TRAP if illegal.
//  - EXEC: ALU result -> ALUOut.
//    - beq/bne: taken -> pc<=pc+imm, else pc<=pc+4; retire; go FETCH.
//    - jal: x[rd]<=pc+4, pc<=pc+imm; retire; go FETCH.
//    - lw/sw: go MEM. ALU/lui: go WB.
//  - MEM: req=1, addr=A+imm, we=sw. On handshake:
//    - lw: MDR<=rdata, go WB.
//    - sw: pc+=4, retire, go FETCH.
//  - WB: x[rd]<=ALUOut (or MDR for lw), pc+=4, retire, go FETCH.
//  - Writes to x0 are discarded; x0 always reads 0.
//  - Latency with zero-wait memory (ready in the same cycle as req):
//    branch/jal 3, ALU/lui/sw 4, lw 5 cycles. Each wait state adds 1.
//  - Handshake: mem_req/we/addr/wdata stay stable until the ready edge; req drops or changes
//    for the next access only after it. mem_ready is ignored while mem_req=0.
//  - Timeout: a counter resets on each new req. If MEM_TIMEOUT cycles pass with no ready,
//    go TRAP (the edge where the count hits MEM_TIMEOUT and ready arrives counts as success).
//  - TRAP triggers: illegal instruction; lw/sw address[1:0]!=0; jump/branch-taken target[1:0]!=0;
//    timeout. In TRAP: mem_req=0, trapped=1, pc/regs frozen. No retire for the faulting
//    instruction. Only rst exits TRAP.
//  - Arithmetic: modulo 2^WIDTH, slt signed. pc+4 and pc+imm wrap silently.
//  - retire and the retired_cnt increment share the same edge. Counter wraps from all-ones to 0.
//  - Reset mid-access: mem_req drops asynchronously. The pending access is abandoned; no reg
//    write, no retire.
// TESTING
//  1. Zero-wait: addi x10,x0,5; addi x10,x10,-7 -> a0=32'hFFFFFFFE after 8 cycles;
//     retired_cnt=2.
//  2. ready held low 3 cycles on a fetch -> req/addr stable throughout; instruction
//     completes 3 cycles later.
//  3. sw x10,8(x0) then lw x11,8(x0) -> store at addr 8 with wdata=a0; x11 equals it;
//     load takes 5 cycles.
//  4. beq x0,x0,-8 at pc=0x10 -> next fetch at 0x08; bne x0,x0 -> next fetch at 0x14.
//  5. lw at address 6, opcode 0x7F, or ready never asserted -> trapped=1, mem_req=0,
//     no retire; after MEM_TIMEOUT=16 the stall case traps.
//  6. Assert rst while mem_req is waiting -> outputs 0 at once; after release, fetch
//     from RESET_PC.

Source files
------------

// File: rtl/riscv_multicycle.sv
// rtl/riscv_multicycle.sv - multi-cycle RV32I-subset core on one shared req/ready memory port
module riscv_multicycle #(
  parameter int                WIDTH       = 32,
  parameter logic [WIDTH-1:0]  RESET_PC    = '0,
  parameter int                MEM_TIMEOUT = 16,
  parameter int                CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic [WIDTH-1:0] a0,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             trapped
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

  state_t           state;
  logic [WIDTH-1:0] pc, ir, a_reg, b_reg, imm_reg, alu_out, mdr;
  logic [WIDTH-1:0] rf [32];
  logic [TW-1:0]    wait_cnt;

  logic [6:0] opcode, f7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];

  logic is_r, is_addi, is_lw, is_sw, is_br, is_jal, is_lui, legal;
  always_comb begin
    is_r = 1'b0; is_addi = 1'b0; is_lw = 1'b0; is_sw = 1'b0;
    is_br = 1'b0; is_jal = 1'b0; is_lui = 1'b0;
    case (opcode)
      7'b0110011: is_r = (f7 == 7'b0000000 && (f3 == 3'b000 || f3 == 3'b110 ||
                                               f3 == 3'b111 || f3 == 3'b010)) ||
                         (f7 == 7'b0100000 && f3 == 3'b000);
      7'b0010011: is_addi = (f3 == 3'b000);
      7'b0000011: is_lw   = (f3 == 3'b010);
      7'b0100011: is_sw   = (f3 == 3'b010);
      7'b1100011: is_br   = (f3 == 3'b000 || f3 == 3'b001);
      7'b1101111: is_jal  = 1'b1;
      7'b0110111: is_lui  = 1'b1;
      default: ;
    endcase
    legal = is_r | is_addi | is_lw | is_sw | is_br | is_jal | is_lui;
  end

  logic [WIDTH-1:0] imm_sel;
  always_comb begin
    if (is_sw)       imm_sel = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    else if (is_br)  imm_sel = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    else if (is_jal) imm_sel = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    else if (is_lui) imm_sel = {ir[31:12], 12'b0};
    else             imm_sel = {{20{ir[31]}}, ir[31:20]};
  end

  logic [WIDTH-1:0] alu_res, target, pc_next;
  logic             slt, br_taken;
  always_comb begin
    slt = $signed(a_reg) < $signed(b_reg);
    if (is_r) begin
      case (f3)
        3'b110:  alu_res = a_reg | b_reg;
        3'b111:  alu_res = a_reg & b_reg;
        3'b010:  alu_res = {{(WIDTH-1){1'b0}}, slt};
        default: alu_res = f7[5] ? a_reg - b_reg : a_reg + b_reg;
      endcase
    end else if (is_lui) begin
      alu_res = imm_reg;
    end else begin
      alu_res = a_reg + imm_reg;
    end
    target   = pc + imm_reg;
    pc_next  = pc + WIDTH'(4);
    br_taken = (f3 == 3'b000) ? (a_reg == b_reg) : (a_reg != b_reg);
  end

  // Request is gated by rst so an in-flight access is dropped the moment reset asserts.
  assign mem_req   = !rst && (state == S_FETCH || state == S_MEM);
  assign mem_we    = mem_req && state == S_MEM && is_sw;
  assign mem_addr  = !mem_req ? '0 : (state == S_FETCH) ? pc : alu_out;
  assign mem_wdata = mem_we ? b_reg : '0;
  assign a0        = rf[10];

  logic timeout;
  assign timeout = !mem_ready && wait_cnt == WAIT_LAST;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH; pc <= RESET_PC; ir <= '0;
      a_reg <= '0; b_reg <= '0; imm_reg <= '0; alu_out <= '0; mdr <= '0;
      wait_cnt <= '0; retire <= 1'b0; retired_cnt <= '0; trapped <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata; wait_cnt <= '0; state <= S_DECODE;
          end else if (timeout) begin
            state <= S_TRAP; trapped <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          a_reg <= rf[rs1]; b_reg <= rf[rs2]; imm_reg <= imm_sel;
          if (legal) state <= S_EXEC;
          else begin state <= S_TRAP; trapped <= 1'b1; end
        end
        S_EXEC: begin
          alu_out <= alu_res;
          if (is_br || is_jal) begin
            // Redirects to a non-word-aligned target fault before anything commits.
            if ((is_jal || br_taken) && target[1:0] != 2'b00) begin
              state <= S_TRAP; trapped <= 1'b1;
            end else begin
              pc <= (is_jal || br_taken) ? target : pc_next;
              if (is_jal && rd != 5'd0) rf[rd] <= pc_next;
              retire <= 1'b1; retired_cnt <= retired_cnt + 1'b1;
              state <= S_FETCH;
            end
          end else if (is_lw || is_sw) begin
            if (alu_res[1:0] != 2'b00) begin state <= S_TRAP; trapped <= 1'b1; end
            else state <= S_MEM;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            if (is_sw) begin
              pc <= pc_next; retire <= 1'b1; retired_cnt <= retired_cnt + 1'b1;
              state <= S_FETCH;
            end else begin
              mdr <= mem_rdata; state <= S_WB;
            end
          end else if (timeout) begin
            state <= S_TRAP; trapped <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WB: begin
          if (rd != 5'd0) rf[rd] <= is_lw ? mdr : alu_out;
          pc <= pc_next; retire <= 1'b1; retired_cnt <= retired_cnt + 1'b1;
          state <= S_FETCH;
        end
        default: state <= S_TRAP;
      endcase
    end
  end

endmodule
